// File: rtl/ysyx_23060184_axi_pkg.sv
// Shared AXI-Lite SRAM definitions: response codes, FSM state enums and the pmem access layer.
// The pmem access layer is a small in-package word memory with pmem_read/pmem_write entry points.
package ysyx_23060184_axi_pkg;
  localparam int ACERR_WIDTH  = 2;
  localparam int WMASK_LENGTH = 4;

  localparam logic [ACERR_WIDTH-1:0] OKAY   = 2'b00;
  localparam logic [ACERR_WIDTH-1:0] SLVERR = 2'b10;
  localparam logic [ACERR_WIDTH-1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  localparam int MODEL_WORDS = 256;
  logic [31:0] mem [MODEL_WORDS];
  int unsigned rd_calls;
  int unsigned wr_calls;

  // Addresses alias modulo the model size; only word-aligned addresses arrive here.
  function automatic int pmem_read(input int raddr);
    int idx;
    idx = (raddr >> 2) & (MODEL_WORDS - 1);
    rd_calls++;
    return mem[idx];
  endfunction

  function automatic void pmem_write(input int waddr, input int wdata, input byte wmask);
    int idx;
    idx = (waddr >> 2) & (MODEL_WORDS - 1);
    wr_calls++;
    for (int b = 0; b < 4; b++)
      if (wmask[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
  endfunction
endpackage

// File: rtl/ysyx_23060184_lat_cnt.sv
// Latency down-counter: load a start value, decrement toward a sticky zero.
module ysyx_23060184_lat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != 0)  cnt <= cnt - 4'd1;
  end

  assign zero = (cnt == 4'd0);
endmodule

// File: rtl/ysyx_23060184_axil_sram.sv
// AXI-Lite slave in front of pmem with independent read/write FSMs and fixed latencies.
// YSYX_23060184_SRAM_RANGE_CHK_EN enables DECERR for addresses outside [BASE, BASE+SIZE).
module ysyx_23060184_axil_sram
  import ysyx_23060184_axi_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter int          ADDR_W = 32,
  parameter int          RD_LAT = 1,
  parameter int          WR_LAT = 1,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter logic [31:0] SIZE   = 32'h0800_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_W-1:0]       rdata,
  output logic [ACERR_WIDTH-1:0]  rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_W-1:0]       awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [WMASK_LENGTH-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ACERR_WIDTH-1:0]  bresp,
  output logic                    bvalid,
  input  logic                    bready
);
`ifdef YSYX_23060184_SRAM_RANGE_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [32:0] lo, hi, x;
    x  = 33'(a);
    lo = {1'b0, BASE};
    hi = lo + {1'b0, SIZE};
    return !CHK_EN || (x >= lo && x < hi);
  endfunction

  // Readies stay low through reset and come up on the first edge after release.
  logic rst_done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_done <= 1'b0;
    else     rst_done <= 1'b1;
  end

  r_state_t          r_state, r_next;
  logic [ADDR_W-1:0] r_addr;
  logic              ar_hs, r_zero, r_fire;

  assign arready = rst_done && (r_state == R_IDLE);
  assign ar_hs   = arvalid && arready;
  assign rvalid  = (r_state == R_RESP);
  assign r_fire  = (r_state == R_WAIT) && r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) r_addr <= araddr;
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs)  r_next = R_WAIT;
      R_WAIT:  if (r_zero) r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  ysyx_23060184_lat_cnt u_rd_cnt (
    .clk(clk), .rst(rst), .load(ar_hs), .load_val(4'(RD_LAT - 1)),
    .dec(r_state == R_WAIT), .zero(r_zero)
  );

  w_state_t                w_state, w_next;
  logic [ADDR_W-1:0]       w_addr;
  logic [DATA_W-1:0]       w_data;
  logic [WMASK_LENGTH-1:0] w_strb;
  logic                    aw_done, w_done, aw_hs, w_hs, w_both, w_zero, w_fire;

  assign awready = rst_done && (w_state == W_IDLE) && !aw_done;
  assign wready  = rst_done && (w_state == W_IDLE) && !w_done;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign w_both  = (w_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);
  assign bvalid  = (w_state == W_RESP);
  assign w_fire  = (w_state == W_WAIT) && w_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) w_addr <= awaddr;
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (w_both) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (w_both) w_next = W_WAIT;
      W_WAIT:  if (w_zero) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  ysyx_23060184_lat_cnt u_wr_cnt (
    .clk(clk), .rst(rst), .load(w_both), .load_val(4'(WR_LAT - 1)),
    .dec(w_state == W_WAIT), .zero(w_zero)
  );

  // Both pmem calls live in one block so a same-edge write lands before the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
      rresp <= OKAY;
      bresp <= OKAY;
    end else begin
      if (w_fire) begin
        if (addr_ok(w_addr))
          pmem_write(int'(32'({w_addr[ADDR_W-1:2], 2'b00})), int'(32'(w_data)), 8'(w_strb));
        bresp <= addr_ok(w_addr) ? OKAY : DECERR;
      end
      if (r_fire) begin
        if (addr_ok(r_addr)) begin
          rdata <= DATA_W'(pmem_read(int'(32'({r_addr[ADDR_W-1:2], 2'b00}))));
          rresp <= OKAY;
        end else begin
          rdata <= '0;
          rresp <= DECERR;
        end
      end
    end
  end
endmodule
